div_seq_32s: RTL

- Multi-cycle signed 32-bit integer divider. It is the inverse operation of the ALU's single-cycle Wallace multiplier.
- It drives the divide path of the multdiv unit: the processor pulses ctrl_DIV, stalls on busy, and captures the result on data_resultRDY.
- The datapath is radix-2 restoring division on operand magnitudes, with sign fix-up at the end.

---
 rtl/div_seq_32s_pkg.sv | 15 +
 rtl/div_seq_32s_step.sv | 24 ++
 rtl/div_seq_32s.sv | 130 +++++++++++++
 3 files changed

// File: rtl/div_seq_32s_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default width and the most-negative dividend used for overflow detection.
package div_seq_32s_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_seq_32s_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// Shifts {R,Q} left by one, trial-subtracts |B| from the widened partial
// remainder and keeps the difference only when it is non-negative.
module div_seq_32s_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_r,
  output logic [WIDTH-1:0] o_q
);

  // One extra bit so the borrow of the trial subtraction is the sign bit.
  logic [WIDTH:0] w_r_sh;
  logic [WIDTH:0] w_t;

  assign w_r_sh = {i_r, i_q[WIDTH-1]};
  assign w_t    = w_r_sh - {1'b0, i_b};

  assign o_r = w_t[WIDTH] ? w_r_sh[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign o_q = {i_q[WIDTH-2:0], ~w_t[WIDTH]};

endmodule

// File: rtl/div_seq_32s.sv
// Multi-cycle signed integer divider (quotient truncated toward zero,
// remainder takes the dividend's sign). Fixed latency of WIDTH+1 edges
// from start acceptance to the one-cycle data_resultRDY pulse.
module div_seq_32s
  import div_seq_32s_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = DIV_OVF_DIVIDEND[DIV_WIDTH-1 -: WIDTH];

  // Two's complement negation in the invert-plus-one adder style.
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  div_state_t r_state;
  div_state_t w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_babs;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_divz;
  logic             r_ovf;

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last;

  assign w_a_s   = data_operandA;
  assign w_b_s   = data_operandB;
  assign w_abs_a = (w_a_s < 0) ? f_neg(data_operandA) : data_operandA;
  assign w_abs_b = (w_b_s < 0) ? f_neg(data_operandB) : data_operandB;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  div_seq_32s_step #(.WIDTH(WIDTH)) u_step (
    .i_r (r_rem),
    .i_q (r_quo),
    .i_b (r_babs),
    .o_r (w_rem_nxt),
    .o_q (w_quo_nxt)
  );

  // State register; reset aborts any in-flight divide.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= DIV_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: start only from IDLE, WIDTH iterations, one DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (ctrl_DIV) w_state_nxt = DIV_CALC;
      DIV_CALC: if (w_last)   w_state_nxt = DIV_DONE;
      DIV_DONE:               w_state_nxt = DIV_IDLE;
      default:                w_state_nxt = DIV_IDLE;
    endcase
  end

  // Busy covers CALC and DONE; it drops together with the ready pulse.
  always_comb begin
    busy = (r_state != DIV_IDLE);
  end

  // Datapath: operand capture, restoring iterations, sign fix-up of results.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt          <= '0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (ctrl_DIV) begin
            r_sign_a <= data_operandA[WIDTH-1];
            r_sign_b <= data_operandB[WIDTH-1];
            r_babs   <= w_abs_b;
            r_quo    <= w_abs_a;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_divz   <= (data_operandB == '0);
            r_ovf    <= (data_operandA == MOST_NEG) && (data_operandB == {WIDTH{1'b1}});
          end
        end
        DIV_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        DIV_DONE: begin
          // Overflow needs no override: |MOST_NEG|/1 negated is MOST_NEG again.
          if (r_divz) begin
            data_result    <= '0;
            data_remainder <= '0;
          end else begin
            data_result    <= (r_sign_a ^ r_sign_b) ? f_neg(r_quo) : r_quo;
            data_remainder <= r_sign_a ? f_neg(r_rem) : r_rem;
          end
          data_exception <= r_divz | r_ovf;
          data_resultRDY <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
